// File: rtl/mc_mem_pkg.sv
// Shared types and helpers for the multicycle memory responder.
package mc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int BYTES = DATA_WIDTH_DEF / 8;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mc_mem_array.sv
// Word storage with byte-enabled synchronous write and a registered read port.
// The read register doubles as the responder's rd output, so it is reset.
module mc_mem_array
    import mc_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int IW         = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [IW-1:0]           idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) rdata_d = mem[idx];
    end

    always_ff @(posedge clk) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mc_mem_responder.sv
// Unified I/D memory responder: accept in IDLE, wait LATENCY cycles, pulse ready.
// Define MC_MEM_MISALIGN_CHECK_EN to flag and suppress accesses with adr[1:0] != 0.
module mc_mem_responder
    import mc_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   adr,
    input  logic [DATA_WIDTH-1:0]   wd,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   rd,
    output logic                    ready,
    output logic                    busy,
    output logic                    err
);

    localparam int IW = idx_width(DEPTH);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic [NB-1:0]   be_q, be_d;
    logic            we_q, we_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            commit, mis, arr_wr, arr_rd;

    // Upper address bits only alias into the same words.
    logic unused_adr;
    assign unused_adr = ^{adr[ADDR_WIDTH-1:IW+2], adr[1:0]};

`ifdef MC_MEM_MISALIGN_CHECK_EN
    logic mis_q, mis_d, err_q, err_d;
    assign mis = mis_q;
`else
    assign mis = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wd_q    <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            be_q    <= be_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

`ifdef MC_MEM_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mis_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
            err_q <= err_d;
        end
    end
`endif

    // Next-state and request latching; later input changes are invisible.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        be_d    = be_q;
        we_d    = we_q;
`ifdef MC_MEM_MISALIGN_CHECK_EN
        mis_d   = mis_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                    idx_d   = adr[IW+1:2];
                    wd_d    = wd;
                    be_d    = be;
                    we_d    = we;
`ifdef MC_MEM_MISALIGN_CHECK_EN
                    mis_d   = (adr[1:0] != 2'b00);
`endif
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state.
    always_comb begin
        commit  = (state_q == WAIT) && (cnt_q == 4'd0);
        arr_wr  = commit && we_q && !mis && !reset;
        arr_rd  = commit && !we_q && !mis && !reset;
        ready_d = (state_d == RESP);
        busy_d  = (state_d != IDLE);
`ifdef MC_MEM_MISALIGN_CHECK_EN
        err_d   = (state_d == RESP) && mis_q;
`endif
    end

    mc_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IW         (IW)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .wr_en (arr_wr),
        .rd_en (arr_rd),
        .idx   (idx_q),
        .wdata (wd_q),
        .be    (be_q),
        .rdata (rd)
    );

    assign ready = ready_q;
    assign busy  = busy_q;
`ifdef MC_MEM_MISALIGN_CHECK_EN
    assign err   = err_q;
`else
    assign err   = 1'b0;
`endif

endmodule
